// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser.
// Holds the FSM encoding and the default opcode and response bytes.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_DO_WRITE,
        ST_DO_READ,
        ST_SEND
    } state_t;

    localparam logic [7:0] OP_WRITE_DEF = 8'h57;
    localparam logic [7:0] OP_READ_DEF  = 8'h52;
    localparam logic [7:0] ACK_DEF      = 8'h4B;
    localparam logic [7:0] NAK_DEF      = 8'h3F;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle timer for the command parser.
// Counts enabled cycles since the last clear; a limit of 0 disables it.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && en && !clr
                     && (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes 'W' addr data / 'R' addr byte commands into register file
// accesses and returns one response byte per command.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] OP_WRITE       = OP_WRITE_DEF,
    parameter logic [7:0] OP_READ        = OP_READ_DEF,
    parameter logic [7:0] ACK_BYTE       = ACK_DEF,
    parameter logic [7:0] NAK_BYTE       = NAK_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       reg_wr_en,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] reg_rd_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic       cmd_err
);

    state_t     state_q, state_d;
    logic       is_wr_q, is_wr_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] tx_q, tx_d;
    logic       in_wait;
    logic       expired;

    assign in_wait = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (!in_wait || rx_valid),
        .en     (in_wait),
        .expired(expired)
    );

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_d      = tx_q;
        reg_wr_en = 1'b0;
        cmd_err   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == OP_WRITE) begin
                    is_wr_d = 1'b1;
                    state_d = ST_GET_ADDR;
                end else if (rx_valid && rx_data == OP_READ) begin
                    is_wr_d = 1'b0;
                    state_d = ST_GET_ADDR;
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid) begin
                    if (rx_data[7:4] != 4'h0) begin
                        tx_d    = NAK_BYTE;
                        cmd_err = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        addr_d  = rx_data[3:0];
                        state_d = is_wr_q ? ST_GET_DATA : ST_DO_READ;
                    end
                end else if (expired) begin
                    cmd_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (rx_valid) begin
                    wdata_d = rx_data;
                    state_d = ST_DO_WRITE;
                end else if (expired) begin
                    cmd_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DO_WRITE: begin
                reg_wr_en = 1'b1;
                tx_d      = ACK_BYTE;
                cmd_err   = rx_valid;
                state_d   = ST_SEND;
            end
            ST_DO_READ: begin
                tx_d    = reg_rd_data;
                cmd_err = rx_valid;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                cmd_err = rx_valid;
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tx_q    <= tx_d;
        end
    end

    assign reg_addr    = addr_q;
    assign reg_wr_data = wdata_q;
    assign tx_data     = tx_q;
    assign tx_valid    = (state_q == ST_SEND);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser with a behavioural register model.
// Directed cases followed by randomized command traffic.
module tb_uart_cmd_parser;

    localparam logic [7:0] ACK = 8'h4B;
    localparam logic [7:0] NAK = 8'h3F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       reg_wr_en;
    logic [3:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       cmd_err;

    logic ready_auto = 1'b1;
    logic ready_man = 1'b1;
    logic ready_rnd = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int err_exp = 0;
    int err_seen = 0;

    logic [7:0]  rf [16];
    logic [7:0]  mdl [16];
    logic [7:0]  exp_tx [$];
    logic [11:0] exp_wr [$];

    bit         hold_q = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] e8;
    logic [11:0] e12;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .reg_wr_en  (reg_wr_en),
        .reg_addr   (reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_rd_data(reg_rd_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    assign tx_ready    = ready_auto ? ready_rnd : ready_man;
    assign reg_rd_data = rf[reg_addr];

    always @(posedge clk) begin
        if (reg_wr_en) rf[reg_addr] <= reg_wr_data;
    end

    always begin
        @(posedge clk);
        #1;
        ready_rnd = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q)
                check(tx_valid && tx_data == hold_data, "tx_stable",
                      {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, hold_data});
            hold_q = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check(1'b0, "tx_unexpected", tx_data, 0);
                end else begin
                    e8 = exp_tx.pop_front();
                    check(tx_data == e8, "tx_data", tx_data, e8);
                end
            end
            if (reg_wr_en) begin
                if (exp_wr.size() == 0) begin
                    check(1'b0, "wr_unexpected", {reg_addr, reg_wr_data}, 0);
                end else begin
                    e12 = exp_wr.pop_front();
                    check({reg_addr, reg_wr_data} == e12, "wr_addr_data",
                          {reg_addr, reg_wr_data}, e12);
                end
            end
            if (cmd_err) err_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            step();
            k++;
        end
        check(!busy, "idle_wait", busy, 0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        send(8'h57);
        gap($urandom_range(0, 8));
        send({4'h0, a});
        gap($urandom_range(0, 8));
        exp_wr.push_back({a, d});
        exp_tx.push_back(ACK);
        mdl[a] = d;
        send(d);
        wait_idle();
    endtask

    task automatic do_read(input logic [3:0] a);
        send(8'h52);
        gap($urandom_range(0, 8));
        exp_tx.push_back(mdl[a]);
        send({4'h0, a});
        wait_idle();
    endtask

    task automatic do_bad(input logic [7:0] op, input logic [7:0] ab);
        send(op);
        gap($urandom_range(0, 8));
        exp_tx.push_back(NAK);
        err_exp++;
        send(ab);
        wait_idle();
    endtask

    task automatic check_zero(input string name);
        check({reg_wr_en, reg_addr, reg_wr_data, tx_valid, tx_data,
               busy, cmd_err} == '0, name,
              {reg_wr_en, reg_addr, reg_wr_data, tx_valid, tx_data,
               busy, cmd_err}, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] ev;
        int k;
        for (int i = 0; i < 16; i++) begin
            rf[i]  = 8'h00;
            mdl[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst = 1'b0;
        gap(2);

        do_write(4'h3, 8'hA5);
        do_read(4'h3);
        do_bad(8'h52, 8'h13);
        do_write(4'hF, 8'h00);
        do_read(4'hF);

        send(8'h00);
        send(8'h41);
        gap(3);
        check(!busy, "unknown_busy", busy, 0);
        check(err_seen == err_exp, "unknown_err", err_seen, err_exp);

        send(8'h57);
        gap(2);
        send(8'h02);
        gap(15);
        check(busy, "timeout_early", busy, 1);
        gap(1);
        check(!busy, "timeout_expire", busy, 0);
        err_exp++;
        check(err_seen == err_exp, "timeout_err", err_seen, err_exp);
        do_read(4'h2);

        ready_auto = 1'b0;
        ready_man  = 1'b0;
        ev = mdl[3];
        exp_tx.push_back(ev);
        send(8'h52);
        send(8'h03);
        k = 0;
        while (!tx_valid && k < 10) begin
            step();
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            check(tx_valid && tx_data == ev, "bp_hold",
                  {tx_valid, tx_data}, {1'b1, ev});
            if (i == 4) begin
                err_exp++;
                send(8'h57);
            end else begin
                step();
            end
        end
        ready_man = 1'b1;
        wait_idle();
        ready_auto = 1'b1;
        check(err_seen == err_exp, "bp_drop_err", err_seen, err_exp);

        send(8'h57);
        send(8'h05);
        gap(2);
        rst = 1'b1;
        gap(2);
        check_zero("reset_midcmd");
        rst = 1'b0;
        gap(3);
        check(!busy, "reset_idle", busy, 0);
        do_read(4'h5);

        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 3) begin
                do_write(4'($urandom), 8'($urandom));
            end else if (k <= 6) begin
                do_read(4'($urandom));
            end else if (k == 7) begin
                b = 8'($urandom_range(1, 15)) << 4 | 8'($urandom_range(0, 15));
                do_bad(($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52, b);
            end else begin
                b = 8'($urandom);
                while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
                send(b);
                gap(2);
            end
        end

        gap(5);
        check(exp_tx.size() == 0, "tx_pending", exp_tx.size(), 0);
        check(exp_wr.size() == 0, "wr_pending", exp_wr.size(), 0);
        check(err_seen == err_exp, "err_count", err_seen, err_exp);
        for (int i = 0; i < 16; i++)
            check(rf[i] == mdl[i], "regfile", rf[i], mdl[i]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
